// File: rtl/pe_stage_pkg.sv
// Shared definitions for the PE operand stager: tile FSM encoding and a
// constant-evaluable ceil(log2) helper used to size FIFO pointers.
package pe_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } tile_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pe_stage_fifo.sv
// Single-channel first-word-fall-through FIFO holding {last, data}.
// The head entry is presented combinationally from registered storage and
// reads as zero while the FIFO is empty.
module pe_stage_fifo
    import pe_stage_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              full,
    output logic              empty
);

    localparam int          AW        = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_wr;
    logic              do_rd;

    // Full refuses writes even when the head is leaving this cycle.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign do_wr = wr_valid & ~full;
    assign do_rd = rd_en & ~empty;

    assign {rd_last, rd_data} = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= {wr_last, wr_data};
    end

endmodule

// File: rtl/pe_operand_stager.sv
// PE operand front-end: NUM_CH FWFT operand FIFOs, sticky per-channel
// write-fin flags split into per-tile and reusable groups, and a tile FSM
// that issues the core load pulse and counts completed tiles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for tile_start
// ST_LOAD | waiting for every channel's fin; then one load_en pulse
// ST_RUN  | core computing; core_cal_fin gives tile_done and counts a tile
module pe_operand_stager
    import pe_stage_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 13,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [NUM_CH-1:0] REUSE_MASK = 4'b1100,
    parameter int                TILE_CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_last,
    output logic [NUM_CH-1:0]          core_valid,
    input  logic [NUM_CH-1:0]          core_ready,
    output logic [NUM_CH*DATA_W-1:0]   core_data,
    output logic [NUM_CH-1:0]          write_fin,
    output logic                       all_write_fin,
    input  logic                       tile_clear,
    input  logic                       reuse_clear,
    input  logic                       tile_start,
    output logic                       load_en,
    input  logic                       core_cal_fin,
    output logic                       tile_done,
    output logic                       busy,
    output logic [TILE_CNT_W-1:0]      tile_count
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] head_last;
    logic [NUM_CH-1:0] deq;
    logic [NUM_CH-1:0] fin_set;
    logic [NUM_CH-1:0] fin_clr;

    tile_state_t state;
    tile_state_t state_nxt;
    logic        load_nxt;
    logic        done_nxt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pe_stage_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .wr_valid (in_valid[gi]),
            .wr_data  (in_data[gi*DATA_W +: DATA_W]),
            .wr_last  (in_last[gi]),
            .rd_en    (deq[gi]),
            .rd_data  (core_data[gi*DATA_W +: DATA_W]),
            .rd_last  (head_last[gi]),
            .full     (full[gi]),
            .empty    (empty[gi])
        );
    end

    // A finished channel hides its FIFO so next-tile words can queue up unseen.
    assign in_ready      = ~full;
    assign core_valid    = ~empty & ~write_fin;
    assign deq           = core_valid & core_ready;
    assign all_write_fin = &write_fin;
    assign busy          = (state != ST_IDLE);

    // Fin set/clear terms; the reusable group only clears once every channel is done.
    always_comb begin
        fin_set = deq & head_last;
        fin_clr = ({NUM_CH{tile_clear}} & ~REUSE_MASK)
                | ({NUM_CH{reuse_clear & all_write_fin}} & REUSE_MASK);
    end

    // Sticky fin flags: clear wins over a coincident set.
    always_ff @(posedge clock) begin
        if (reset) write_fin <= '0;
        else       write_fin <= (write_fin | fin_set) & ~fin_clr;
    end

    // Tile FSM next state and pulse requests.
    always_comb begin
        state_nxt = state;
        load_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: if (tile_start) state_nxt = ST_LOAD;
            ST_LOAD: if (all_write_fin) begin
                state_nxt = ST_RUN;
                load_nxt  = 1'b1;
            end
            ST_RUN: if (core_cal_fin) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, registered pulses and the wrapping tile counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            load_en    <= 1'b0;
            tile_done  <= 1'b0;
            tile_count <= '0;
        end else begin
            state     <= state_nxt;
            load_en   <= load_nxt;
            tile_done <= done_nxt;
            if (done_nxt) tile_count <= tile_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_operand_stager.sv
// Self-checking bench for pe_operand_stager: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_pe_operand_stager;

    localparam int          NCH   = 4;
    localparam int          DW    = 13;
    localparam int          DEPTH = 4;
    localparam logic [3:0]  REUSE = 4'b1100;

    logic              clock;
    logic              reset;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_last;
    logic [NCH-1:0]    core_valid;
    logic [NCH-1:0]    core_ready;
    logic [NCH*DW-1:0] core_data;
    logic [NCH-1:0]    write_fin;
    logic              all_write_fin;
    logic              tile_clear;
    logic              reuse_clear;
    logic              tile_start;
    logic              load_en;
    logic              core_cal_fin;
    logic              tile_done;
    logic              busy;
    logic [15:0]       tile_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: word queues, fin flags, tile phase (0 idle, 1 wait fins, 2 computing).
    logic [DW:0] mq [NCH][$];
    logic [3:0]  m_fin;
    int          m_phase;
    logic        m_load;
    logic        m_done;
    logic [15:0] m_cnt;

    pe_operand_stager dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .core_valid    (core_valid),
        .core_ready    (core_ready),
        .core_data     (core_data),
        .write_fin     (write_fin),
        .all_write_fin (all_write_fin),
        .tile_clear    (tile_clear),
        .reuse_clear   (reuse_clear),
        .tile_start    (tile_start),
        .load_en       (load_en),
        .core_cal_fin  (core_cal_fin),
        .tile_done     (tile_done),
        .busy          (busy),
        .tile_count    (tile_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_step();
        logic [3:0]  nfin;
        logic        fin_all;
        logic [DW:0] h;
        nfin    = m_fin;
        fin_all = (m_fin == 4'hF);
        for (int i = 0; i < NCH; i++) begin
            bit can_take;
            can_take = mq[i].size() < DEPTH;
            if (mq[i].size() > 0 && !m_fin[i] && core_ready[i]) begin
                h = mq[i].pop_front();
                if (h[DW]) nfin[i] = 1'b1;
            end
            if (in_valid[i] && can_take) mq[i].push_back({in_last[i], in_data[i*DW +: DW]});
            if (tile_clear && !REUSE[i]) nfin[i] = 1'b0;
            if (reuse_clear && fin_all && REUSE[i]) nfin[i] = 1'b0;
        end
        m_load = 1'b0;
        m_done = 1'b0;
        if (m_phase == 0) begin
            if (tile_start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (fin_all) begin m_phase = 2; m_load = 1'b1; end
        end else begin
            if (core_cal_fin) begin m_phase = 0; m_done = 1'b1; m_cnt = m_cnt + 16'd1; end
        end
        m_fin = nfin;
        if (reset) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_fin = '0; m_phase = 0; m_load = 1'b0; m_done = 1'b0; m_cnt = '0;
        end
    endtask

    // Advance one clock: model samples the inputs, outputs are settled at the next negedge.
    task automatic step();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_data = '0; in_last = '0; core_ready = '0;
        tile_clear = 0; reuse_clear = 0; tile_start = 0; core_cal_fin = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %h expected f", in_ready); end
        checks++; if (core_valid !== 4'h0) begin errors++; $display("FAIL reset_core_valid got %h expected 0", core_valid); end
        checks++; if (core_data !== '0) begin errors++; $display("FAIL reset_core_data got %h expected 0", core_data); end
        checks++; if (write_fin !== 4'h0) begin errors++; $display("FAIL reset_write_fin got %h expected 0", write_fin); end
        checks++; if ({load_en, tile_done, busy} !== 3'b000) begin errors++; $display("FAIL reset_fsm_outs got %b expected 000", {load_en, tile_done, busy}); end
        checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL reset_tile_count got %0d expected 0", tile_count); end
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 4; k++) begin
            in_valid[0] = 1'b1; in_data[0 +: DW] = DW'(k); in_last[0] = (k == 4);
            step();
        end
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_full got %b expected 0", in_ready[0]); end
        in_data[0 +: DW] = 13'h005; in_last[0] = 1'b0;
        step();
        in_valid = '0;
        checks++; if (core_data[0 +: DW] !== 13'h001) begin errors++; $display("FAIL fill_head got %h expected 001", core_data[0 +: DW]); end
        core_ready[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (core_valid[0] !== 1'b1 || core_data[0 +: DW] !== DW'(k)) begin
                errors++; $display("FAIL drain_word%0d got v=%b d=%h expected v=1 d=%h", k, core_valid[0], core_data[0 +: DW], DW'(k));
            end
            step();
        end
        checks++; if (write_fin[0] !== 1'b1 || core_valid[0] !== 1'b0) begin errors++; $display("FAIL drain_fin got fin=%b v=%b expected fin=1 v=0", write_fin[0], core_valid[0]); end
        core_ready = '0; tile_clear = 1'b1;
        step();
        tile_clear = 1'b0;
        checks++; if (write_fin[0] !== 1'b0 || core_valid[0] !== 1'b0) begin errors++; $display("FAIL fifth_refused got fin=%b v=%b expected 0 0", write_fin[0], core_valid[0]); end
    endtask

    task automatic test_fin_blocking();
        core_ready[1] = 1'b1;
        in_valid[1] = 1'b1; in_data[DW +: DW] = 13'h011; in_last[1] = 1'b1;
        step();
        in_valid = '0; in_last = '0;
        step();
        checks++; if (write_fin[1] !== 1'b1) begin errors++; $display("FAIL blk_fin_set got %b expected 1", write_fin[1]); end
        in_valid[1] = 1'b1; in_data[DW +: DW] = 13'h0AA;
        step();
        in_valid = '0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (core_valid[1] !== 1'b0) begin errors++; $display("FAIL blk_hidden%0d got %b expected 0", k, core_valid[1]); end
            step();
        end
        tile_clear = 1'b1;
        step();
        tile_clear = 1'b0;
        checks++;
        if (core_valid[1] !== 1'b1 || core_data[DW +: DW] !== 13'h0AA) begin
            errors++; $display("FAIL blk_release got v=%b d=%h expected v=1 d=0aa", core_valid[1], core_data[DW +: DW]);
        end
        step();
        core_ready = '0;
    endtask

    task automatic test_group_clears();
        core_ready = 4'hF; in_valid = 4'hF; in_last = 4'hF;
        for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = DW'($urandom);
        step();
        in_valid = '0; in_last = '0;
        step();
        core_ready = '0;
        checks++; if (write_fin !== 4'hF) begin errors++; $display("FAIL grp_all_set got %b expected 1111", write_fin); end
        reuse_clear = 1'b1; step(); reuse_clear = 1'b0;
        checks++; if (write_fin !== 4'b0011) begin errors++; $display("FAIL grp_reuse_clear got %b expected 0011", write_fin); end
        reuse_clear = 1'b1; step(); reuse_clear = 1'b0;
        checks++; if (write_fin !== 4'b0011) begin errors++; $display("FAIL grp_reuse_ignored got %b expected 0011", write_fin); end
        tile_clear = 1'b1; step(); tile_clear = 1'b0;
        checks++; if (write_fin !== 4'b0000) begin errors++; $display("FAIL grp_tile_clear got %b expected 0000", write_fin); end
    endtask

    task automatic test_tile_flow();
        tile_start = 1'b1; step(); tile_start = 1'b0;
        checks++; if (busy !== 1'b1 || load_en !== 1'b0) begin errors++; $display("FAIL flow_load_state got busy=%b load=%b expected 1 0", busy, load_en); end
        core_ready = 4'hF; in_valid = 4'hF; in_last = 4'hF;
        step();
        in_valid = '0; in_last = '0;
        step();
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL flow_load_early got %b expected 0", load_en); end
        step();
        checks++; if (load_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flow_load_pulse got load=%b busy=%b expected 1 1", load_en, busy); end
        step();
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL flow_load_single got %b expected 0", load_en); end
        tile_start = 1'b1; step(); tile_start = 1'b0;
        checks++; if (busy !== 1'b1 || load_en !== 1'b0 || tile_done !== 1'b0) begin errors++; $display("FAIL flow_start_in_run got busy=%b load=%b done=%b expected 1 0 0", busy, load_en, tile_done); end
        core_cal_fin = 1'b1; step(); core_cal_fin = 1'b0;
        checks++;
        if (tile_done !== 1'b1 || tile_count !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL flow_done got done=%b cnt=%0d busy=%b expected 1 1 0", tile_done, tile_count, busy);
        end
        tile_clear = 1'b1; reuse_clear = 1'b1; step(); tile_clear = 1'b0; reuse_clear = 1'b0;
        checks++; if (tile_done !== 1'b0 || write_fin !== 4'h0) begin errors++; $display("FAIL flow_after got done=%b fin=%b expected 0 0000", tile_done, write_fin); end
        core_ready = '0;
    endtask

    task automatic test_simul_set_clear();
        in_valid[0] = 1'b1; in_data[0 +: DW] = 13'h0F0; in_last[0] = 1'b1; step();
        in_data[0 +: DW] = 13'h0F1; in_last[0] = 1'b0; step();
        in_valid = '0;
        core_ready[0] = 1'b1; tile_clear = 1'b1; step();
        core_ready = '0; tile_clear = 1'b0;
        checks++;
        if (write_fin[0] !== 1'b0 || core_valid[0] !== 1'b1 || core_data[0 +: DW] !== 13'h0F1) begin
            errors++; $display("FAIL simul_clear got fin=%b v=%b d=%h expected 0 1 0f1", write_fin[0], core_valid[0], core_data[0 +: DW]);
        end
        core_ready[0] = 1'b1; step(); core_ready = '0;
        checks++; if (core_valid[0] !== 1'b0 || write_fin[0] !== 1'b0) begin errors++; $display("FAIL simul_drain got v=%b fin=%b expected 0 0", core_valid[0], write_fin[0]); end
    endtask

    task automatic test_reset_mid_tile();
        tile_start = 1'b1; step(); tile_start = 1'b0;
        core_ready = 4'hF; in_valid = 4'hF; in_last = 4'hF; step();
        in_valid = '0; in_last = '0; step(); step();
        core_ready = '0;
        checks++; if (busy !== 1'b1 || tile_count !== 16'd1) begin errors++; $display("FAIL mid_pre got busy=%b cnt=%0d expected 1 1", busy, tile_count); end
        in_valid[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin in_data[2*DW +: DW] = DW'(k + 16'h100); step(); end
        in_valid = '0;
        reset = 1'b1; core_cal_fin = 1'b1; step();
        reset = 1'b0; core_cal_fin = 1'b0;
        checks++; if (in_ready !== 4'hF || core_valid !== 4'h0 || write_fin !== 4'h0) begin errors++; $display("FAIL mid_fifo got rdy=%b v=%b fin=%b expected 1111 0000 0000", in_ready, core_valid, write_fin); end
        checks++; if (busy !== 1'b0 || tile_count !== 16'd0 || tile_done !== 1'b0 || load_en !== 1'b0) begin errors++; $display("FAIL mid_fsm got busy=%b cnt=%0d done=%b load=%b expected 0 0 0 0", busy, tile_count, tile_done, load_en); end
        step();
        checks++; if (tile_done !== 1'b0 || core_data !== '0) begin errors++; $display("FAIL mid_after got done=%b data=%h expected 0 0", tile_done, core_data); end
    endtask

    task automatic test_random();
        logic [3:0]        e_ready, e_valid;
        logic [NCH*DW-1:0] e_data;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                e_ready[i] = mq[i].size() < DEPTH;
                e_valid[i] = mq[i].size() > 0 && !m_fin[i];
                e_data[i*DW +: DW] = (mq[i].size() > 0) ? mq[i][0][DW-1:0] : '0;
            end
            checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_in_ready c%0d got %b expected %b", cyc, in_ready, e_ready); end
            checks++; if (core_valid !== e_valid) begin errors++; $display("FAIL rnd_core_valid c%0d got %b expected %b", cyc, core_valid, e_valid); end
            checks++; if (core_data !== e_data) begin errors++; $display("FAIL rnd_core_data c%0d got %h expected %h", cyc, core_data, e_data); end
            checks++; if (write_fin !== m_fin || all_write_fin !== (m_fin == 4'hF)) begin errors++; $display("FAIL rnd_fin c%0d got %b/%b expected %b", cyc, write_fin, all_write_fin, m_fin); end
            checks++; if (load_en !== m_load || tile_done !== m_done) begin errors++; $display("FAIL rnd_pulses c%0d got %b%b expected %b%b", cyc, load_en, tile_done, m_load, m_done); end
            checks++; if (busy !== (m_phase != 0) || tile_count !== m_cnt) begin errors++; $display("FAIL rnd_busy_cnt c%0d got %b/%0d expected %b/%0d", cyc, busy, tile_count, (m_phase != 0), m_cnt); end
            for (int i = 0; i < NCH; i++) begin
                in_valid[i]   = $urandom_range(0, 1);
                in_last[i]    = ($urandom_range(0, 3) == 0);
                core_ready[i] = $urandom_range(0, 2) != 0;
                in_data[i*DW +: DW] = DW'($urandom);
            end
            tile_clear   = ($urandom_range(0, 15) == 0);
            reuse_clear  = ($urandom_range(0, 7) == 0);
            tile_start   = ($urandom_range(0, 7) == 0);
            core_cal_fin = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            step();
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        m_fin = '0; m_phase = 0; m_load = 1'b0; m_done = 1'b0; m_cnt = '0;
        @(negedge clock);
        test_reset();
        test_fill_drain();
        test_fin_blocking();
        test_group_clears();
        test_tile_flow();
        test_simul_set_clear();
        test_reset_mid_tile();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_operand_stager.md
Name: pe_operand_stager

Overview:
- Parametrised successor of the PE operand front-end: NUM_CH independent operand streams, for example iact address, iact data, weight address and weight data.
- Each stream passes through a configurable-depth FIFO into the PE core.
- Per channel, it tracks end-of-tile completion with sticky write-fin flags, cleared in two groups: the per-tile group and the reusable group.
- A small tile FSM issues the core load pulse and reports tile completion, replacing the hard-wired four-channel handling with a generic, mask-configured block.

Parameters:
- NUM_CH, 4, number of operand channels.
- DATA_W, 13, payload width per channel. Narrower operands are zero-extended by the instantiator.
- FIFO_DEPTH, 4, entries per channel FIFO. Power of two, at least 2.
- REUSE_MASK, 4'b1100, bit i = 1 puts channel i in the reusable (weight) group; 0 puts it in the per-tile (iact) group.
- TILE_CNT_W, 16, width of the completed-tile counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel producer valid.
- in_ready  out  NUM_CH  per-channel producer ready.
- in_data  in  NUM_CH*DATA_W  payloads. Channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  NUM_CH  marks the final word of a channel's tile.
- core_valid  out  NUM_CH  head-of-FIFO valid toward the core.
- core_ready  in  NUM_CH  core consumes the head word.
- core_data  out  NUM_CH*DATA_W  head payloads.
- write_fin  out  NUM_CH  sticky per-channel fin flags.
- all_write_fin  out  1  AND of write_fin.
- tile_clear  in  1  clears the fins of the per-tile group.
- reuse_clear  in  1  clears the fins of the reusable group; honoured only while all_write_fin = 1.
- tile_start  in  1  requests a new tile.
- load_en  out  1  one-cycle core load pulse.
- core_cal_fin  in  1  core calculation done.
- tile_done  out  1  one-cycle completion pulse.
- busy  out  1  FSM not in IDLE.
- tile_count  out  TILE_CNT_W  completed tiles, wraps modulo 2^TILE_CNT_W.

Behaviour:
- **Reset:**
  - All FIFOs empty, all fins 0, FSM in IDLE, tile_count = 0.
  - in_ready = all 1s, core_valid = 0, load_en = 0, tile_done = 0, busy = 0.
  - core_data = 0 while empty.
  - Reset mid-tile discards FIFO contents and fins with no pulses.
- **FIFO (per channel):**
  - Stores {last, data}.
  - in_ready = !full. ready does not depend on a same-cycle dequeue, so a full FIFO refuses a write even while it is being read.
  - Enqueue on in_valid & in_ready.
  - First-word fall-through: core_valid = !empty & !write_fin[i]; core_data is the head entry, combinational from registered storage.
  - Dequeue on core_valid & core_ready.
  - Simultaneous enqueue and dequeue on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- **Write-fin:**
  - write_fin[i] is set the cycle after a dequeue whose head has last = 1.
  - While write_fin[i] = 1, core_valid[i] is forced 0. This blocks the core from reading the next tile's words, which may keep accumulating in the FIFO.
  - Priority per flag: reset > clear > set > hold.
  - tile_clear clears every i with REUSE_MASK[i] = 0.
  - reuse_clear & all_write_fin clears every i with REUSE_MASK[i] = 1. reuse_clear while all_write_fin = 0 is ignored.
  - If a clear and a set coincide on the same channel, the flag ends 0; the last word is still consumed.
- **Tile FSM:**
  - IDLE: tile_start moves to LOAD.
  - LOAD: when all_write_fin = 1, assert load_en for exactly one cycle and move to RUN. This may happen on the first cycle in LOAD if the fins are already set.
  - RUN: on core_cal_fin, assert tile_done for one cycle, increment tile_count, and return to IDLE.
  - tile_start is ignored outside IDLE. core_cal_fin is ignored outside RUN.
  - All FSM outputs are registered: load_en and tile_done appear the cycle after the triggering condition.
  - busy = (state != IDLE).

Decomposition:
- Shared package pe_stage_pkg holds the FSM state encoding (IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2) and a clog2 helper function.
- One sub-module, pe_stage_fifo: single-channel FWFT FIFO with {last, data} storage and full/empty outputs. It is instantiated NUM_CH times in a generate loop.
- Fin flags and the FSM stay in the top module.

Test Plan:
- Fill and drain: push 4 words (0x001..0x004, last on the 4th) into ch0 with core_ready = 0. Expect in_ready[0] = 0 after the 4th write and a 5th push not accepted. Drain with core_ready = 1 and expect 0x001..0x004 in order, with write_fin[0] = 1 the cycle after 0x004 is dequeued.
- Fin blocking: after write_fin[1] = 1, push 0x0AA into ch1. Expect core_valid[1] = 0 until tile_clear; the cycle after tile_clear, core_valid[1] = 1 with core_data = 0x0AA.
- Group clears: set all 4 fins, pulse reuse_clear. Expect write_fin = 4'b0011. Pulse reuse_clear again with all_write_fin = 0 and expect no change. Pulse tile_clear and expect 4'b0000.
- Tile flow: tile_start, then complete all 4 channels' last words. Expect one load_en pulse and busy = 1. Drive core_cal_fin and expect tile_done for 1 cycle, tile_count = 1, busy = 0. A tile_start during RUN has no effect.
- Simultaneous set and clear: dequeue ch0's last word in the same cycle as tile_clear. Expect write_fin[0] = 0 afterwards and the FIFO occupancy decremented.
- Reset mid-tile: reset asserted in RUN with 3 words queued. The next cycle shows all FIFOs empty, write_fin = 0, FSM in IDLE, tile_count = 0, and no tile_done pulse.
